d_issue_ctrl: RTL and testbench

//  Issue/hazard scheduler for the decode stage. Holds a per-register

---
 rtl/d_issue_ctrl.sv | 115 +++++++++++
 tb/tb_d_issue_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/d_issue_ctrl.sv
// rtl/d_issue_ctrl.sv - decode-stage issue/hazard scheduler with writeback scoreboard and branch flush FSM
module d_issue_ctrl #(
    parameter int NREG      = 32,
    parameter int SEL_W     = 5,
    parameter int CNT_W     = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [SEL_W-1:0] regA,
    input  logic [SEL_W-1:0] regB,
    input  logic             use_a,
    input  logic             use_b,
    input  logic [SEL_W-1:0] regD,
    input  logic             w_en,
    input  logic             is_branch,
    input  logic             wb_valid,
    input  logic [SEL_W-1:0] wb_sel,
    input  logic             br_resolved,
    input  logic             br_taken,
    output logic             issue,
    output logic             stall_fd,
    output logic             flush_fd,
    output logic             sb_err
);

    localparam int              FC_W    = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BR_WAIT,
        S_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             sb_err_q, sb_err_d;

    logic hazard;
    logic inc_en;
    logic dec_en;
    logic wb_zero;
    logic same_reg;

    always_comb begin
        hazard = 1'b0;
        if (use_a && (regA != '0) && (cnt_q[regA] != '0)) hazard = 1'b1;
        if (use_b && (regB != '0) && (cnt_q[regB] != '0)) hazard = 1'b1;
        // A saturated counter cannot take another in-flight write.
        if (w_en && (regD != '0) && (cnt_q[regD] == CNT_MAX)) hazard = 1'b1;
    end

    // Outputs are gated by reset so they drop as soon as reset asserts.
    always_comb begin
        issue    = reset & d_valid & ~hazard & (state_q == S_IDLE);
        flush_fd = reset & (state_q == S_FLUSH);
        stall_fd = reset & d_valid & ~issue & ~flush_fd;
        sb_err   = sb_err_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        inc_en   = issue & w_en & (regD != '0);
        wb_zero  = wb_valid & (wb_sel != '0) & (cnt_q[wb_sel] == '0);
        dec_en   = wb_valid & (wb_sel != '0) & (cnt_q[wb_sel] != '0);
        same_reg = inc_en & dec_en & (regD == wb_sel);
        sb_err_d = sb_err_q | wb_zero;
        if (inc_en && !same_reg) cnt_d[regD] = cnt_q[regD] + CNT_W'(1);
        if (dec_en && !same_reg) cnt_d[wb_sel] = cnt_q[wb_sel] - CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                if (issue && is_branch) state_d = S_BR_WAIT;
            end
            S_BR_WAIT: begin
                if (br_resolved) begin
                    if (br_taken) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYC);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                fcnt_d = fcnt_q - FC_W'(1);
                if (fcnt_q <= FC_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            sb_err_q <= 1'b0;
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            sb_err_q <= sb_err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_d_issue_ctrl.sv
// tb/tb_d_issue_ctrl.sv - directed and random checks of d_issue_ctrl against a behavioural model
module tb_d_issue_ctrl;

    localparam int FLUSH_CYC = 2;
    localparam int CMAX      = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       d_valid, use_a, use_b, w_en, is_branch, wb_valid, br_resolved, br_taken;
    logic [4:0] regA, regB, regD, wb_sel;
    logic       issue, stall_fd, flush_fd, sb_err;

    int total = 0;
    int bad   = 0;

    // Behavioural model: pending-write counts, a branch mode and remaining flush cycles.
    int mcnt [32];
    int mode;        // 0 free, 1 waiting for branch, 2 flushing
    int flush_left;
    bit merr;

    d_issue_ctrl #(.NREG(32), .SEL_W(5), .CNT_W(2), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .regA(regA), .regB(regB),
        .use_a(use_a), .use_b(use_b), .regD(regD), .w_en(w_en), .is_branch(is_branch),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .br_resolved(br_resolved), .br_taken(br_taken),
        .issue(issue), .stall_fd(stall_fd), .flush_fd(flush_fd), .sb_err(sb_err)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        mode = 0; flush_left = 0; merr = 0;
    endtask

    function automatic bit exp_issue();
        bit blocked;
        blocked = (use_a && regA != 0 && mcnt[regA] > 0) ||
                  (use_b && regB != 0 && mcnt[regB] > 0) ||
                  (w_en && regD != 0 && mcnt[regD] >= CMAX);
        return reset && d_valid && !blocked && mode == 0;
    endfunction

    task automatic cmp(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic chk(input string tag);
        bit ei, ef;
        ei = exp_issue();
        ef = reset && mode == 2;
        cmp({tag, ".issue"}, issue, ei);
        cmp({tag, ".flush"}, flush_fd, ef);
        cmp({tag, ".stall"}, stall_fd, reset && d_valid && !ei && !ef);
        cmp({tag, ".sb_err"}, sb_err, merr);
    endtask

    task automatic model_edge();
        bit ei;
        int inc_r, dec_r;
        ei = exp_issue();
        inc_r = (ei && w_en && regD != 0) ? int'(regD) : -1;
        dec_r = -1;
        if (wb_valid && wb_sel != 0) begin
            if (mcnt[wb_sel] == 0) merr = 1;
            else dec_r = int'(wb_sel);
        end
        if (inc_r >= 0) mcnt[inc_r]++;
        if (dec_r >= 0) mcnt[dec_r]--;
        case (mode)
            0: if (ei && is_branch) mode = 1;
            1: if (br_resolved) begin
                   if (br_taken) begin mode = 2; flush_left = FLUSH_CYC; end
                   else mode = 0;
               end
            default: begin
                flush_left--;
                if (flush_left == 0) mode = 0;
            end
        endcase
    endtask

    // Check combinational outputs mid-cycle, then advance one clock.
    task automatic step(input string tag);
        #2;
        chk(tag);
        @(posedge clock);
        if (reset) model_edge();
        #1;
    endtask

    task automatic quiet();
        d_valid = 0; use_a = 0; use_b = 0; w_en = 0; is_branch = 0;
        wb_valid = 0; br_resolved = 0; br_taken = 0;
        regA = 0; regB = 0; regD = 0; wb_sel = 0;
    endtask

    initial begin
        reset = 0;
        quiet();
        model_clear();
        d_valid = 1; use_a = 1; regA = 3;
        #3;
        chk("reset_held");
        @(posedge clock);
        #1 reset = 1;

        step("t1_read_r3");

        quiet(); d_valid = 1; w_en = 1; regD = 5;
        step("t2_write_r5");
        quiet(); d_valid = 1; use_a = 1; regA = 5;
        step("t2_stall_a");
        step("t2_stall_b");
        wb_valid = 1; wb_sel = 5;
        step("t2_no_bypass");
        wb_valid = 0;
        step("t2_after_retire");

        quiet(); d_valid = 1; w_en = 1; regD = 0;
        step("t3_write_r0");
        quiet(); d_valid = 1; use_a = 1; regA = 0;
        step("t3_read_r0");

        quiet(); d_valid = 1; w_en = 1; regD = 7;
        step("t4_write_r7");
        wb_valid = 1; wb_sel = 7;
        step("t4_inc_dec_r7");
        quiet(); d_valid = 1; use_a = 1; regA = 7;
        step("t4_r7_pending");
        wb_valid = 1; wb_sel = 7;
        step("t4_retire_r7");
        quiet(); wb_valid = 1; wb_sel = 9;
        step("t4_retire_r9_empty");
        quiet();
        step("t4_sb_err_set");
        step("t4_sb_err_sticky");

        quiet(); d_valid = 1; is_branch = 1;
        step("t5_branch_issue");
        quiet(); d_valid = 1;
        step("t5_br_wait");
        br_resolved = 1; br_taken = 1;
        step("t5_resolve_taken");
        quiet(); d_valid = 1;
        step("t5_flush1");
        step("t5_flush2");
        step("t5_resume");
        is_branch = 1;
        step("t5_branch2");
        quiet(); d_valid = 1; br_resolved = 1; br_taken = 0;
        step("t5_resolve_not_taken");
        quiet(); d_valid = 1;
        step("t5_resume2");

        d_valid = 1; is_branch = 1;
        step("t6_branch");
        quiet(); br_resolved = 1; br_taken = 1;
        step("t6_resolve");
        quiet(); d_valid = 1;
        #2 chk("t6_in_flush");
        reset = 0;
        #1;
        model_clear();
        chk("t6_async_drop");
        @(posedge clock);
        #3 reset = 1;
        @(posedge clock);
        #1;
        quiet(); d_valid = 1; use_a = 1; use_b = 1; regA = 5; regB = 7;
        step("t6_after_reset");

        for (int n = 0; n < 400; n++) begin
            int r;
            quiet();
            d_valid   = ($urandom_range(3, 0) != 0);
            use_a     = $urandom_range(1, 0) == 1;
            use_b     = $urandom_range(1, 0) == 1;
            w_en      = $urandom_range(1, 0) == 1;
            regA      = 5'($urandom_range(7, 0));
            regB      = 5'($urandom_range(7, 0));
            regD      = 5'($urandom_range(7, 0));
            is_branch = ($urandom_range(9, 0) == 0);
            r = $urandom_range(7, 1);
            if ($urandom_range(1, 0) == 1 && mcnt[r] > 0) begin
                wb_valid = 1; wb_sel = 5'(r);
            end
            br_resolved = ($urandom_range(2, 0) == 0);
            br_taken    = $urandom_range(1, 0) == 1;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
